// File: rtl/ether_pkg.sv
// ether_pkg: shared FSM encoding and constants for the RMII transmit path.
// The CRC step helper is only used by builds with ETHER_TX_FCS_EN.
package ether_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam int FCS_DIBITS = 16;

  // Reflected CRC-32 over one dibit, bit 0 first.
  function automatic logic [31:0] crc32_dibit_step(
    input logic [31:0] c,
    input logic [1:0] d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) begin
        r = (r >> 1) ^ CRC_POLY_REFL;
      end else begin
        r = r >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ether_tx_arbiter_crc.sv
// crc32_dibit: running Ethernet CRC-32 fed one dibit per cycle.
// init restarts the sum; a dibit presented with init is folded into the fresh sum.
module crc32_dibit
  import ether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] base;

  always_comb begin
    base  = init ? CRC_INIT : crc_q;
    crc_d = base;
    if (en) begin
      crc_d = crc32_dibit_step(base, d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ether_tx_arbiter.sv
// ether_tx_arbiter: round-robin owner of the RMII TX pins, framing each grant.
// Define ETHER_TX_FCS_EN to append a CRC-32 FCS after the payload.
module ether_tx_arbiter
  import ether_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PREAMBLE_DIBITS = 31,
  parameter int IFG_DIBITS = 48,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   axiiv,
  input  logic [2*NUM_REQ-1:0] axiid,
  input  logic [NUM_REQ-1:0]   axiil,
  output logic [NUM_REQ-1:0]   axiir,
  output logic                 txen,
  output logic [1:0]           txd,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 underrun
);

  localparam int CMAX0 = (PREAMBLE_DIBITS > IFG_DIBITS) ?
                         PREAMBLE_DIBITS : IFG_DIBITS;
  localparam int CMAX = (CMAX0 > FCS_DIBITS) ? CMAX0 : FCS_DIBITS;
  localparam int CW = $clog2(CMAX + 1);

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           gv_q, gv_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           last_q, last_d;
  logic           txen_q, txen_d;
  logic [1:0]     txd_q, txd_d;
  logic           und_q, und_d;

  logic           arb_hit;
  logic [IDW-1:0] arb_sel;
  logic           arb_go;
  logic           v_sel;
  logic           l_sel;
  logic [1:0]     d_sel;
  logic           rdy;
  logic           acc;
  logic           und_ev;

`ifdef ETHER_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs_sr_q, fcs_sr_d;

  crc32_dibit u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (state_q == ST_SFD),
    .en   (acc),
    .d    (d_sel),
    .crc  (crc)
  );
`endif

  assign v_sel  = axiiv[gid_q];
  assign l_sel  = axiil[gid_q];
  assign d_sel  = axiid[{gid_q, 1'b0} +: 2];
  assign rdy    = (state_q == ST_SFD) ||
                  (state_q == ST_PAYLOAD && !last_q);
  assign acc    = rdy && v_sel;
  assign und_ev = rdy && !v_sel;
  assign arb_go = (state_q == ST_IDLE) ||
                  (state_q == ST_IFG && cnt_q == '0);

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    arb_hit = 1'b0;
    arb_sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        arb_hit = 1'b1;
        arb_sel = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      txen_q  <= 1'b0;
      txd_q   <= 2'b00;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      und_q   <= und_d;
    end
  end

`ifdef ETHER_TX_FCS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fcs_sr_q <= '0;
    end else begin
      fcs_sr_q <= fcs_sr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
`ifdef ETHER_TX_FCS_EN
    fcs_sr_d = fcs_sr_q;
`endif
    unique case (state_q)
      ST_PREAMBLE: begin
        if (cnt_q == '0) begin
          state_d = ST_SFD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_SFD, ST_PAYLOAD: begin
        if (state_q == ST_PAYLOAD && last_q) begin
          last_d = 1'b0;
`ifdef ETHER_TX_FCS_EN
          state_d  = ST_FCS;
          cnt_d    = CW'(FCS_DIBITS - 1);
          fcs_sr_d = ~crc >> 2;
`else
          state_d = ST_IFG;
          cnt_d   = CW'(IFG_DIBITS - 1);
`endif
        end else if (acc) begin
          state_d = ST_PAYLOAD;
          last_d  = l_sel;
        end else begin
          state_d = ST_IFG;
          cnt_d   = CW'(IFG_DIBITS - 1);
        end
      end
`ifdef ETHER_TX_FCS_EN
      ST_FCS: begin
        fcs_sr_d = fcs_sr_q >> 2;
        if (cnt_q == '0) begin
          state_d = ST_IFG;
          cnt_d   = CW'(IFG_DIBITS - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      ST_IFG: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          gv_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
    // The IFG exit cycle arbitrates too, so back-to-back gaps stay exact.
    if (arb_go && arb_hit) begin
      state_d = ST_PREAMBLE;
      cnt_d   = CW'(PREAMBLE_DIBITS - 1);
      gv_d    = 1'b1;
      gid_d   = arb_sel;
      ptr_d   = IDW'((int'(arb_sel) + 1) % NUM_REQ);
    end
  end

  always_comb begin
    txen_d = 1'b0;
    txd_d  = 2'b00;
    und_d  = und_ev;
    unique case (state_d)
      ST_PREAMBLE: begin
        txen_d = 1'b1;
        txd_d  = PREAMBLE_DIBIT;
      end
      ST_SFD: begin
        txen_d = 1'b1;
        txd_d  = SFD_DIBIT;
      end
      ST_PAYLOAD: begin
        txen_d = 1'b1;
        txd_d  = d_sel;
      end
`ifdef ETHER_TX_FCS_EN
      ST_FCS: begin
        txen_d = 1'b1;
        txd_d  = (state_q == ST_PAYLOAD) ? ~crc[1:0] : fcs_sr_q[1:0];
      end
`endif
      default: ;
    endcase
  end

  assign axiir       = rdy ? (NUM_REQ'(1) << gid_q) : '0;
  assign txen        = txen_q;
  assign txd         = txd_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;
  assign underrun    = und_q;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// tb_ether_tx_arbiter: scoreboard bench for the RMII TX arbiter.
// Accepted payload dibits are queued and matched against the wire.
`timescale 1ns/1ps
module tb_ether_tx_arbiter;

  localparam int NR  = 2;
  localparam int PRE = 31;
  localparam int IFG = 48;
`ifdef ETHER_TX_FCS_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] axiiv = '0;
  logic [2*NR-1:0] axiid = '0;
  logic [NR-1:0] axiil = '0;
  logic [NR-1:0] axiir;
  logic          txen;
  logic [1:0]    txd;
  logic          grant_valid;
  logic [0:0]    grant_id;
  logic          underrun;

  ether_tx_arbiter #(
    .NUM_REQ         (NR),
    .PREAMBLE_DIBITS (PRE),
    .IFG_DIBITS      (IFG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .axiil       (axiil),
    .axiir       (axiir),
    .txen        (txen),
    .txd         (txd),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .underrun    (underrun)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0] d;
    logic       l;
    logic       stall;
  } src_t;

  typedef struct {
    logic [1:0] d;
    int         cyc;
  } exp_t;

  src_t src_q [NR][$];
  exp_t exp_q[$];
  int   gid_obs[$];
  int   gap_obs[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;

  int          pos, pre_err, tail_n, low_run, und_cnt, n_pay;
  bit          in_frame, had_end, prev_txen;
  logic [31:0] tail_w, mcrc, last_fcs;
  exp_t        e;
  src_t        s;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [1:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 2; i++) begin
      fb = r[0] ^ d[i];
      r = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Monitor (wire side) then requester drivers, all on the falling edge.
  always @(negedge clk) begin
    logic [NR-1:0]   v;
    logic [2*NR-1:0] d;
    logic [NR-1:0]   l;
    if (rst_at_edge) begin
      in_frame  = 1'b0;
      had_end   = 1'b0;
      prev_txen = 1'b0;
      low_run   = 0;
      pos       = 0;
    end else begin
      if (txen) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          pos = 0; pre_err = 0; tail_n = 0;
          tail_w = '0; mcrc = 32'hFFFFFFFF;
          gid_obs.push_back(int'(grant_id));
          gap_obs.push_back(had_end ? low_run : -1);
        end
        if (pos < PRE) begin
          if (txd !== 2'b01) pre_err++;
        end else if (pos == PRE) begin
          if (txd !== 2'b11) pre_err++;
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("payload", 32'(txd), 32'(e.d));
          mcrc = crc_upd(mcrc, e.d);
          n_pay++;
        end else begin
          if (tail_n < 16) tail_w[2*tail_n +: 2] = txd;
          tail_n++;
        end
        pos++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          had_end  = 1'b1;
          low_run  = 0;
          chk("preamble_sfd", pre_err, 0);
          chk("trailer_len", tail_n, (FCS_ON && !underrun) ? 16 : 0);
`ifdef ETHER_TX_FCS_EN
          if (!underrun) chk("fcs_model", tail_w, ~mcrc);
`endif
          last_fcs = tail_w;
        end
        low_run++;
      end
      if (underrun) begin
        und_cnt++;
        chk("und_txen", 32'(txen), 0);
        chk("und_prev_txen", 32'(prev_txen), 1);
      end
      prev_txen = txen;
    end

    v = '0; d = '0; l = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        s = src_q[i][0];
        if (s.stall) begin
          if (axiir[i]) void'(src_q[i].pop_front());
        end else begin
          v[i] = 1'b1;
          d[2*i +: 2] = s.d;
          l[i] = s.l;
          if (axiir[i]) begin
            e.d = s.d;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
            void'(src_q[i].pop_front());
          end
        end
      end
    end
    axiiv = v; axiid = d; axiil = l;
  end

  task automatic add(input int i, input logic [1:0] d, input bit last);
    src_t t;
    t.d = d; t.l = last; t.stall = 1'b0;
    src_q[i].push_back(t);
  endtask

  task automatic add_stall(input int i);
    src_t t;
    t.d = 2'b00; t.l = 1'b0; t.stall = 1'b1;
    src_q[i].push_back(t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gid_obs.delete();
    gap_obs.delete();
  endtask

  // Waits for a frame, drops req once it starts, then measures the IFG.
  task automatic run_frame(input string tag, input int tmo, output int ifg_n);
    int t;
    ifg_n = -1;
    t = 0;
    while (!txen && t < 300) begin @(negedge clk); t++; end
    if (!txen) begin chk({tag, "_start_timeout"}, 0, 1); return; end
    req = '0;
    t = 0;
    while (txen && t < tmo) begin @(negedge clk); t++; end
    if (txen) begin chk({tag, "_end_timeout"}, 0, 1); return; end
    ifg_n = 0;
    while (grant_valid && !txen && ifg_n < 200) begin
      @(negedge clk);
      ifg_n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] pat1 [8] = '{2'b11, 2'b01, 2'b10, 2'b00,
                           2'b01, 2'b11, 2'b00, 2'b10};

  initial begin
    int n, t, p0;
    und_cnt = 0;
    n_pay = 0;
    repeat (3) @(negedge clk);
    chk("rst_txen", 32'(txen), 0);
    chk("rst_txd", 32'(txd), 0);
    chk("rst_axiir", 32'(axiir), 0);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) add(0, pat1[k], k == 7);
    req = 2'b01;
    run_frame("single", 500, n);
    chk("single_ifg", n, IFG);
    chk("single_gv_end", 32'(grant_valid), 0);
    chk("single_gid", gid_obs.size() > 0 ? gid_obs[0] : 99, 0);
    chk("single_sb", exp_q.size(), 0);

    do_reset();
    for (int k = 0; k < 5; k++) add(0, 2'(k), k == 4);
    for (int k = 0; k < 5; k++) add(0, ~2'(k), k == 4);
    for (int k = 0; k < 7; k++) add(1, 2'(k) ^ 2'b01, k == 6);
    req = 2'b11;
    t = 0;
    while (gid_obs.size() < 3 && t < 1000) begin @(negedge clk); t++; end
    req = '0;
    t = 0;
    while (grant_valid && t < 1000) begin @(negedge clk); t++; end
    chk("rr_frames", gid_obs.size(), 3);
    chk("rr_gid0", gid_obs.size() > 0 ? gid_obs[0] : 99, 0);
    chk("rr_gid1", gid_obs.size() > 1 ? gid_obs[1] : 99, 1);
    chk("rr_gid2", gid_obs.size() > 2 ? gid_obs[2] : 99, 0);
    chk("rr_gap1", gap_obs.size() > 1 ? gap_obs[1] : -2, IFG);
    chk("rr_gap2", gap_obs.size() > 2 ? gap_obs[2] : -2, IFG);
    chk("rr_sb", exp_q.size(), 0);

    gid_obs.delete();
    und_cnt = 0;
    for (int k = 0; k < 4; k++) add(1, 2'(k), 1'b0);
    add_stall(1);
    req = 2'b10;
    run_frame("und", 500, n);
    chk("und_ifg", n, IFG);
    chk("und_pulses", und_cnt, 1);
    chk("und_gv_end", 32'(grant_valid), 0);
    chk("und_gid", gid_obs.size() > 0 ? gid_obs[0] : 99, 1);
    chk("und_sb", exp_q.size(), 0);
    chk("und_src_drained", src_q[1].size(), 0);

    gid_obs.delete();
    req = 2'b10;
    t = 0;
    while (!txen && t < 300) begin @(negedge clk); t++; end
    repeat (9) @(negedge clk);
    chk("rstm_pre_gid", 32'(grant_id), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstm_txen", 32'(txen), 0);
    chk("rstm_txd", 32'(txd), 0);
    chk("rstm_gv", 32'(grant_valid), 0);
    chk("rstm_gid", 32'(grant_id), 0);
    for (int k = 0; k < 3; k++) add(1, 2'(k + 1), k == 2);
    req = 2'b10;
    run_frame("rstm", 500, n);
    chk("rstm_ifg", n, IFG);
    chk("rstm_frames", gid_obs.size(), 2);
    chk("rstm_gid_new", gid_obs.size() > 1 ? gid_obs[1] : 99, 1);

    p0 = n_pay;
    for (int k = 0; k < 6040; k++) add(0, (k % 3 == 0) ? 2'b11 : 2'b01, k == 6039);
    req = 2'b01;
    run_frame("loop", 7000, n);
    chk("loop_count", n_pay - p0, 6040);
    chk("loop_ifg", n, IFG);
    chk("loop_sb", exp_q.size(), 0);

`ifdef ETHER_TX_FCS_EN
    for (int k = 0; k < 16; k++) add(0, 2'b00, k == 15);
    req = 2'b01;
    run_frame("fcs", 500, n);
    chk("fcs_zero4", last_fcs, 32'h2144DF1C);
    chk("fcs_ifg", n, IFG);
`endif

    chk("sb_final", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
